// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and helpers shared by the UART receiver and transmitter.
//   uart_state_e       : frame-level FSM state encoding
//   CLOCK_FREQ_DEFAULT : default system clock in Hz
//   BAUD_DEFAULT       : default line rate in bits/s
//   calc_div()         : clk cycles per oversampling tick (integer floor)
// Configuration macro: UART_RX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLOCK_FREQ_DEFAULT = 16000000;
    localparam int BAUD_DEFAULT       = 9600;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
        WAIT_HIGH = 3'd4,
        PARITY    = 3'd5
`else
        WAIT_HIGH = 3'd4
`endif
    } uart_state_e;

    function automatic int calc_div(input int clock_freq, input int baud,
                                    input int oversample);
        return clock_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-clk tick every DIV cycles.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, restarts the count at 0
//   tick  : high for one clk when the counter is at DIV-1
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick = (cnt_q == LAST);
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver: start/stop framed, LSB first.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   rx         : asynchronous serial line, idle high
//   data_out   : received character (held stable while valid)
//   valid      : data_out holds an unconsumed character
//   ready      : consumer takes data_out when valid && ready
//   busy       : frame in progress (state != IDLE)
//   frame_err  : one-clk pulse, stop bit sampled low
//   overrun    : one-clk pulse, character dropped because valid was held
//   parity_err : one-clk pulse with delivery on parity mismatch
//                (only with UART_RX_PARITY_EN)
//   state_dbg  : current FSM state, for observation
// Handshake: valid rises with a new character and stays high, with data_out
// frozen, until the first cycle where ready is also high; a character
// arriving while valid && !ready is dropped and reported on overrun.
// Configuration macro: UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = CLOCK_FREQ_DEFAULT,
    parameter int BAUD       = BAUD_DEFAULT,
    parameter int OVERSAMPLE = 16,
    parameter int WIDTH      = 8,
`ifdef UART_RX_PARITY_EN
    parameter int PARITY_ODD = 0,
`endif
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err,
`endif
    output uart_state_e      state_dbg
);

    localparam int DIV = calc_div(CLOCK_FREQ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(WIDTH + 1);
    localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(WIDTH - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e      state_q, state_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic [OSW-1:0]   os_q, os_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_q, par_bit_d;
    logic             parity_err_q, parity_err_d;
`endif
    logic             rxs;
    logic             tick;
    logic             clr;
    logic             deliver;

    assign rxs = sync2_q;

    // Counter is restarted on the start edge so samples land mid-bit.
    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        sync1_d     = rx;
        sync2_d     = sync1_q;
        state_d     = state_q;
        os_d        = os_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q && !ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        clr         = 1'b0;
        deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    clr     = 1'b1;
                    os_d    = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (os_q == HALF_LAST) begin
                        // A start bit that has returned high by mid-bit is a glitch.
                        os_d    = '0;
                        bit_d   = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_q == OS_LAST) begin
                        os_d    = '0;
                        shreg_d = {rxs, shreg_q[WIDTH-1:1]};
                        if (bit_q == BIT_LAST) begin
                            stop_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (os_q == OS_LAST) begin
                        os_d      = '0;
                        par_bit_d = rxs;
                        stop_d    = 1'b0;
                        state_d   = STOP;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (os_q == OS_LAST) begin
                        os_d = '0;
                        if (!rxs) begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_HIGH;
                        end else if (stop_q == STOP_LAST) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            stop_d = stop_q + 1'b1;
                        end
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                // Holding here until the line idles keeps a break to one error.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = ((^shreg_q) ^ par_bit_q) != 1'(PARITY_ODD);
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            os_q        <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            os_q        <= os_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif
    assign state_dbg = state_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the counterpart to the team's start/stop-framed, LSB-first transmitter.
- Samples an asynchronous rx line on the 16 MHz system clock using an internal oversampling tick.
- Recovers WIDTH-bit characters and delivers them on a valid/ready handshake.
- Sits between a board pin and the hub's internal byte consumers; flags framing and overrun errors.

Parameters:
- CLOCK_FREQ, 16000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- OVERSAMPLE, 16, ticks per bit period; must be even and at least 8.
- WIDTH, 8, data bits per character.
- STOP_BITS, 1, stop bits checked per frame (1 or 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous, idle high.
- data_out  output  WIDTH  received character, LSB is the first bit on the wire.
- valid  output  1  data_out holds an unconsumed character.
- ready  input  1  consumer accepts data_out on a cycle where valid && ready.
- busy  output  1  a frame is in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse: a stop bit was sampled low.
- overrun  output  1  one-cycle pulse: a character was dropped because valid was still held.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values: data_out=0, valid=0, busy=0, frame_err=0, overrun=0, state=IDLE. Both synchroniser flops reset to 1.
- Input path: rx passes through a 2-flop synchroniser. All logic uses the synchronised value rxs.
- Tick generation:
  - DIV = CLOCK_FREQ/(BAUD*OVERSAMPLE), integer floor; 104 at the defaults.
  - Tick counter runs 0..DIV-1; tick asserts for one clk at DIV-1.
  - The counter is cleared on the IDLE->START transition so sampling is edge-aligned.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rxs==0 -> START; clear the tick counter and the sub-bit counter.
  - START: after OVERSAMPLE/2 ticks (mid start bit), sample rxs. If 1 -> IDLE (glitch; no flags). If 0 -> DATA with bit count 0.
  - DATA: every OVERSAMPLE ticks, sample and shift: shreg <= {rxs, shreg[WIDTH-1:1]}. After WIDTH samples -> STOP.
  - STOP: every OVERSAMPLE ticks, sample one stop bit, STOP_BITS times.
    - Any stop sample 0: pulse frame_err, do not deliver the character, go to WAIT_HIGH.
    - All stop samples 1: deliver the character, go to IDLE. This happens at mid stop bit, giving half a bit of resync margin.
  - WAIT_HIGH: remain until rxs==1, then IDLE. A held-low break line yields exactly one frame_err.
- Delivery, on the clk following the final stop-bit sample:
  - If valid==0, or valid && ready in the same cycle: data_out <= shreg, valid <= 1.
  - If valid && !ready: keep the old data_out and valid, pulse overrun, drop the new character.
- Handshake:
  - valid drops on the cycle after valid && ready unless a new delivery coincides.
  - data_out is stable while valid==1.
- Reset mid-frame: all state returns to reset values immediately; the partial character is discarded.
- End-to-end latency: valid rises about 2 clk synchroniser delay plus (WIDTH+1.5)*OVERSAMPLE*DIV clk after the line's falling start edge.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Adds a parameter PARITY_ODD (default 0 = even) and an output parity_err (1-bit one-cycle pulse).
  - Adds a PARITY state between DATA and STOP, sampled after OVERSAMPLE ticks.
  - On mismatch, parity_err pulses with the delivery cycle. The character is still delivered; the consumer decides whether to use it.
- When undefined: no PARITY state, no parity_err port; frame length is 1+WIDTH+STOP_BITS.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum typedef (shared with the transmitter's future FSM);
  - CLOCK_FREQ_DEFAULT and BAUD_DEFAULT;
  - a function computing DIV.
- One sub-module, uart_baud_tick:
  - parameterised divider with synchronous clear input and tick output;
  - reusable by the transmitter to replace its toggled-clock generator.

Test Plan:
- Send 0xB5 at 9600 baud with ready=1 -> one valid pulse, data_out=0xB5, frame_err=0, overrun=0.
- Drive rx low for 500 clk (less than half a bit) from idle -> busy asserts then clears; no valid, no frame_err.
- Send 0x3C with the stop bit forced low, then hold rx low 3 bit times -> exactly one frame_err pulse, valid stays 0, busy held until rx returns high.
- Hold ready=0 and send 0x55 then 0xAA -> data_out=0x55, valid=1, overrun pulses once at the second delivery. Then pulse ready -> valid falls.
- Assert rst_n=0 at data bit 4 of a frame, release, then send 0x81 -> no stale output; data_out=0x81 delivered correctly.
- With UART_RX_PARITY_EN defined and even parity, send 0x07 with parity bit 0 -> data_out=0x07, valid=1, parity_err pulses once.
